// File: rtl/prog_freq_div.sv
// Programmable divider: emits a one-cycle tick every div_i cycles on clk, plus a
// registered square wave, a busy flag and a wrapping tick counter.
module prog_freq_div #(
    parameter int WIDTH  = 8,
    parameter int TICK_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              oneshot_i,
    input  logic              start_i,
    input  logic [WIDTH-1:0]  div_i,
    input  logic              clr_i,
    output logic              tick_o,
    output logic              sq_o,
    output logic              busy_o,
    output logic [TICK_W-1:0] ticks_o,
    output logic              wrap_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_reg;
    logic [WIDTH-1:0]    cnt_reg;
    logic [WIDTH-1:0]    div_reg;
    logic                mode_reg;
    logic                tick_reg;
    logic                sq_reg;
    logic                busy_reg;
    logic [TICK_W-1:0]   ticks_reg;
    logic                wrap_reg;

    logic [WIDTH-1:0]    cnt_inc;
    logic [WIDTH:0]      half_cur;
    logic                period_end;
    logic                start_ok;
    logic                reload_ok;

    assign cnt_inc    = cnt_reg + WIDTH'(1);
    // One extra bit so div_s = 2^WIDTH-1 does not overflow the rounding add
    assign half_cur   = ({1'b0, div_reg} + (WIDTH+1)'(1)) >> 1;
    assign period_end = (state_reg == RUN) && en_i && (cnt_reg == div_reg - WIDTH'(1));
    assign start_ok   = en_i && (div_i != '0) && (!oneshot_i || start_i);
    assign reload_ok  = !mode_reg && !oneshot_i && (div_i != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            div_reg   <= '0;
            mode_reg  <= 1'b0;
            tick_reg  <= 1'b0;
            sq_reg    <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (start_ok) begin
                        state_reg <= RUN;
                        div_reg   <= div_i;
                        mode_reg  <= oneshot_i;
                        sq_reg    <= 1'b1;
                        busy_reg  <= 1'b1;
                    end else begin
                        sq_reg   <= 1'b0;
                        busy_reg <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en_i) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        sq_reg    <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (period_end) begin
                        cnt_reg  <= '0;
                        tick_reg <= 1'b1;
                        // Shadow registers only change here, so the period in flight is never altered
                        if (reload_ok) begin
                            div_reg  <= div_i;
                            mode_reg <= oneshot_i;
                            sq_reg   <= 1'b1;
                            busy_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            sq_reg    <= 1'b0;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        cnt_reg  <= cnt_inc;
                        sq_reg   <= ({1'b0, cnt_inc} < half_cur);
                        busy_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    sq_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Clear takes priority over a coincident tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ticks_reg <= '0;
            wrap_reg  <= 1'b0;
        end else if (clr_i) begin
            ticks_reg <= '0;
            wrap_reg  <= 1'b0;
        end else if (period_end) begin
            ticks_reg <= ticks_reg + TICK_W'(1);
            wrap_reg  <= &ticks_reg;
        end else begin
            wrap_reg  <= 1'b0;
        end
    end

    assign tick_o  = tick_reg;
    assign sq_o    = sq_reg;
    assign busy_o  = busy_reg;
    assign ticks_o = ticks_reg;
    assign wrap_o  = wrap_reg;

endmodule

// File: tb/tb_prog_freq_div.sv
// Bench for prog_freq_div: fixed vector table, directed corner sequences and a
// randomized run against a period-position reference model (two TICK_W values).
module tb_prog_freq_div;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en_i = 1'b0, oneshot_i = 1'b0, start_i = 1'b0, clr_i = 1'b0;
    logic [7:0] div_i = 8'd0;

    logic       tick_a, sq_a, busy_a, wrap_a;
    logic [6:0] ticks_a;
    logic       tick_b, sq_b, busy_b, wrap_b;
    logic [2:0] ticks_b;

    int n_vec = 0;
    int n_err = 0;

    prog_freq_div #(.WIDTH(8), .TICK_W(7)) dut_a (
        .clk(clk), .reset(reset), .en_i(en_i), .oneshot_i(oneshot_i), .start_i(start_i),
        .div_i(div_i), .clr_i(clr_i), .tick_o(tick_a), .sq_o(sq_a), .busy_o(busy_a),
        .ticks_o(ticks_a), .wrap_o(wrap_a)
    );

    prog_freq_div #(.WIDTH(8), .TICK_W(3)) dut_b (
        .clk(clk), .reset(reset), .en_i(en_i), .oneshot_i(oneshot_i), .start_i(start_i),
        .div_i(div_i), .clr_i(clr_i), .tick_o(tick_b), .sq_o(sq_b), .busy_o(busy_b),
        .ticks_o(ticks_b), .wrap_o(wrap_b)
    );

    always #5 clk = ~clk;

    // Reference model: position within the current period, period length and mode
    bit m_run, m_mode;
    int m_pos, m_p;
    bit e_tick, e_sq, e_busy, e_wrap_a, e_wrap_b;
    int e_ticks_a, e_ticks_b;

    task automatic model_reset();
        m_run = 0; m_mode = 0; m_pos = 0; m_p = 0;
        e_tick = 0; e_sq = 0; e_busy = 0;
        e_wrap_a = 0; e_wrap_b = 0; e_ticks_a = 0; e_ticks_b = 0;
    endtask

    task automatic count_upd(inout int cnt, inout bit wr, input int modulus, input bit cl, input bit t);
        if (cl) begin
            cnt = 0; wr = 0;
        end else if (t) begin
            cnt = (cnt + 1) % modulus;
            wr  = (cnt == 0);
        end else begin
            wr = 0;
        end
    endtask

    task automatic model_step(input bit en, input bit os, input bit st, input int dv, input bit cl);
        bit t;
        t = 0;
        if (!m_run) begin
            if (en && dv != 0 && (!os || st)) begin
                m_run = 1; m_pos = 0; m_p = dv; m_mode = os;
            end
        end else if (!en) begin
            m_run = 0; m_pos = 0;
        end else if (m_pos + 1 == m_p) begin
            t = 1; m_pos = 0;
            if (!m_mode && !os && dv != 0) m_p = dv;
            else m_run = 0;
        end else begin
            m_pos++;
        end
        e_tick = t;
        e_busy = m_run;
        e_sq   = m_run && (m_pos < (m_p + 1) / 2);
        count_upd(e_ticks_a, e_wrap_a, 128, cl, t);
        count_upd(e_ticks_b, e_wrap_b, 8, cl, t);
    endtask

    task automatic check_all(input string name);
        logic [15:0] act, exp;
        act = {5'd0, tick_a, sq_a, busy_a, wrap_a, ticks_a};
        exp = {5'd0, e_tick, e_sq, e_busy, e_wrap_a, 7'(e_ticks_a)};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut_a t=%0t {tick,sq,busy,wrap,ticks} got=%h want=%h", name, $time, act, exp);
        end
        act = {9'd0, tick_b, sq_b, busy_b, wrap_b, ticks_b};
        exp = {9'd0, e_tick, e_sq, e_busy, e_wrap_b, 3'(e_ticks_b)};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut_b t=%0t {tick,sq,busy,wrap,ticks} got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input bit en, input bit os, input bit st, input int dv, input bit cl, input string name);
        en_i = en; oneshot_i = os; start_i = st; div_i = 8'(dv); clr_i = cl;
        @(posedge clk);
        model_step(en, os, st, dv, cl);
        #1;
        check_all(name);
    endtask

    // Called one time unit after an edge: asserts reset between edges
    task automatic reset_mid(input string name);
        reset = 1'b1;
        model_reset();
        #2;
        check_all(name);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        bit en; bit os; bit st; int dv; bit cl;
        bit tk; bit sq; bit bz; int tc;
    } vec_t;

    vec_t tbl[22];

    initial begin
        tbl[0]  = '{1,0,0,4,0, 0,1,1,0};
        tbl[1]  = '{1,0,0,4,0, 0,1,1,0};
        tbl[2]  = '{1,0,0,4,0, 0,0,1,0};
        tbl[3]  = '{1,0,0,4,0, 0,0,1,0};
        tbl[4]  = '{1,0,0,4,0, 1,1,1,1};
        tbl[5]  = '{1,0,0,4,0, 0,1,1,1};
        tbl[6]  = '{1,0,0,4,0, 0,0,1,1};
        tbl[7]  = '{1,0,0,4,0, 0,0,1,1};
        tbl[8]  = '{1,0,0,4,0, 1,1,1,2};
        tbl[9]  = '{0,0,0,4,0, 0,0,0,2};
        tbl[10] = '{1,0,0,0,0, 0,0,0,2};
        tbl[11] = '{1,0,0,5,0, 0,1,1,2};
        tbl[12] = '{1,0,0,5,0, 0,1,1,2};
        tbl[13] = '{1,0,0,5,0, 0,1,1,2};
        tbl[14] = '{1,0,0,5,0, 0,0,1,2};
        tbl[15] = '{1,0,0,5,0, 0,0,1,2};
        tbl[16] = '{1,0,0,5,0, 1,1,1,3};
        tbl[17] = '{0,0,0,5,0, 0,0,0,3};
        tbl[18] = '{1,0,0,1,0, 0,1,1,3};
        tbl[19] = '{1,0,0,1,0, 1,1,1,4};
        tbl[20] = '{1,0,0,1,0, 1,1,1,5};
        tbl[21] = '{0,0,0,1,0, 0,0,0,5};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Vector table from reset: div 4, stop, div 0, div 5, div 1
        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].en, tbl[i].os, tbl[i].st, tbl[i].dv, tbl[i].cl, "tbl_model");
            chk($sformatf("tbl[%0d]", i), {tick_a, sq_a, busy_a, ticks_a},
                {tbl[i].tk, tbl[i].sq, tbl[i].bz, 7'(tbl[i].tc)});
        end

        // Divisor change at cnt=1, then divisor 0 mid-period
        reset_mid("rst_div_chg");
        cyc(1,0,0,4,0, "div_chg");
        cyc(1,0,0,4,0, "div_chg");
        for (int i = 0; i < 16; i++) cyc(1,0,0,6,0, "div_chg6");
        for (int i = 0; i < 10; i++) cyc(1,0,0,0,0, "div_zero");
        chk("div_zero_idle", busy_a, 0);

        // One-shot: single tick 3 cycles after start, second start ignored
        reset_mid("rst_oneshot");
        cyc(1,1,1,3,0, "os_start");
        chk("os_busy", busy_a, 1);
        cyc(1,1,0,3,0, "os_run");
        cyc(1,1,1,3,0, "os_restart");
        cyc(1,1,0,3,0, "os_tick");
        chk("os_tick", tick_a, 1);
        chk("os_busy_fall", busy_a, 0);
        for (int i = 0; i < 4; i++) cyc(1,1,0,3,0, "os_after");

        // Tick counter wrap on TICK_W=3 and clear-vs-tick priority
        reset_mid("rst_wrap");
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 40 && !hit; i++) begin
                cyc(1,0,0,2,0, "wrap_run");
                hit = (ticks_b == 3'd7);
            end
            chk("wrap_reach7", hit, 1);
            hit = 0;
            for (int i = 0; i < 4 && !hit; i++) begin
                cyc(1,0,0,2,0, "wrap_run");
                hit = tick_a;
            end
            chk("wrap_tick", hit, 1);
            chk("wrap_pulse", wrap_b, 1);
            chk("wrap_zero", ticks_b, 0);
            cyc(1,0,0,2,0, "pre_clr");
            cyc(1,0,0,2,1, "clr_tick");
            chk("clr_tick_still", tick_a, 1);
            chk("clr_ticks_a", ticks_a, 0);
            chk("clr_wrap_b", wrap_b, 0);
        end

        // Async reset mid-period, restart, en dropped mid-period
        for (int i = 0; i < 5; i++) cyc(1,0,0,7,0, "pre_rst");
        reset_mid("rst_mid");
        for (int i = 0; i < 8; i++) cyc(1,0,0,5,0, "post_rst");
        cyc(0,0,0,5,0, "en_drop");
        for (int i = 0; i < 3; i++) cyc(0,0,0,5,0, "en_low");

        // Randomized run
        begin
            bit en, os, st, cl;
            int dv, r;
            dv = 4;
            for (int i = 0; i < 3000; i++) begin
                en = ($urandom_range(0, 99) < 92);
                os = ($urandom_range(0, 99) < 20);
                st = ($urandom_range(0, 99) < 30);
                cl = ($urandom_range(0, 99) < 4);
                if ($urandom_range(0, 99) < 8) begin
                    r = $urandom_range(0, 99);
                    if (r < 5) dv = 0;
                    else if (r < 88) dv = $urandom_range(1, 9);
                    else dv = $urandom_range(200, 255);
                end
                cyc(en, os, st, dv, cl, "rand");
                if ($urandom_range(0, 999) < 3) reset_mid("rand_rst");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_freq_div.md
Name: prog_freq_div

Overview:
Parametrised programmable frequency divider that generates a one-cycle tick every div_i clock cycles, plus a registered square wave. It replaces derived-clock dividers: all logic runs on clk, and downstream counters use tick_o as an enable. It adds glitch-free divisor reload at period boundaries, a one-shot mode, a 50%-duty output and a wrapping tick counter with a wrap flag. It sits between the input switches (divisor/control) and the bidirectional output pins.

Parameters:
WIDTH, 8, width of divisor and period counter
TICK_W, 7, width of tick counter ticks_o

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
en_i  input  1  global enable
oneshot_i  input  1  0 = continuous mode, 1 = one-shot mode
start_i  input  1  one-shot trigger, level sampled each edge
div_i  input  WIDTH  divisor; 0 = stop
clr_i  input  1  synchronous clear of ticks_o
tick_o  output  1  registered one-cycle tick per period
sq_o  output  1  registered square wave
busy_o  output  1  high while state = RUN
ticks_o  output  TICK_W  count of ticks, wraps
wrap_o  output  1  one-cycle pulse when ticks_o wraps to 0

Behaviour:
- Clock: clk only. Reset: asynchronous, active-high. No derived clocks; every register is clocked by clk and cleared by reset.
- Reset values: state = IDLE, cnt = 0, div_s = 0, mode_s = 0, and tick_o, sq_o, busy_o, ticks_o, wrap_o all 0. Reset asserted mid-run aborts immediately, with no tick.
- Internal shadow registers: div_s (WIDTH bits) and mode_s (1 bit). They are loaded only on entry to RUN or at a wrap, so div_i and oneshot_i changes never shorten or stretch the current period.
- FSM states:
  - IDLE -> RUN, continuous: en_i=1 and oneshot_i=0 and div_i!=0.
  - IDLE -> RUN, one-shot: en_i=1 and oneshot_i=1 and start_i=1 and div_i!=0.
  - On entry: cnt <= 0, div_s <= div_i, mode_s <= oneshot_i.
  - RUN, en_i=0: next edge -> IDLE, cnt <= 0, no tick.
  - RUN, en_i=1, cnt != div_s-1: cnt <= cnt+1, tick_o <= 0.
  - RUN, en_i=1, cnt == div_s-1 (wrap): cnt <= 0, tick_o <= 1. Next state:
    - mode_s=1: -> IDLE.
    - mode_s=0 and oneshot_i=0 and div_i!=0: stay RUN, reload div_s and mode_s.
    - otherwise: -> IDLE.
  - start_i is ignored in RUN.
- Latency: with RUN entered at edge E0, the first tick_o is high in the cycle after edge E0+div_s. The continuous period is exactly div_s cycles.
- div_s = 1: tick_o stays high continuously while in RUN.
- sq_o: a register whose value in each cycle equals (cnt < (div_s+1)>>1), computed in WIDTH+1 bits to avoid overflow at div_s = 2^WIDTH-1. sq_o is 0 in IDLE. High phase is ceil(div_s/2) cycles, low phase is floor(div_s/2) cycles. The high phase begins in the cycle where cnt = 0.
- busy_o = (state == RUN), registered.
- Tick counter:
  - Increments ticks_o on each edge that sets tick_o.
  - At 2^TICK_W-1 it wraps to 0 and wrap_o <= 1 for that one cycle. wrap_o is otherwise 0.
  - clr_i=1: ticks_o <= 0, wrap_o <= 0. Clear wins over a simultaneous tick: the counter is not incremented and wrap_o is not asserted, but tick_o is still asserted.
- Arithmetic is unsigned. cnt is WIDTH bits. cnt never exceeds div_s-1.

Test Plan:
- WIDTH=8, div_i=4, continuous, en_i=1 -> tick_o high 1 cycle every 4. sq_o pattern 1,1,0,0 repeating. busy_o=1. ticks_o increments 1,2,3…
- div_i=5 -> sq_o high 3 cycles, low 2. div_i=1 -> tick_o constantly 1 and ticks_o increments every cycle. div_i=0 -> stays IDLE, all outputs 0.
- Running with div_i=4, change to div_i=6 at cnt=1 -> current period still 4 cycles, then periods of 6. Set div_i=0 mid-period -> the final tick still occurs, then IDLE.
- oneshot_i=1, div_i=3, 1-cycle start_i -> exactly one tick_o, 3 cycles after the start edge. busy_o falls with the tick. A second start_i during RUN is ignored.
- TICK_W=3, continuous div_i=2 -> ticks_o reaches 7, then 0 with wrap_o pulse coincident with tick_o. clr_i asserted on the same edge as a tick -> ticks_o=0, wrap_o=0.
- Reset asserted asynchronously mid-period (between edges) -> all outputs 0 immediately. After release, the first tick comes div_i cycles after RUN entry. en_i dropped mid-period -> IDLE next edge, no tick.
